// File: rtl/spi_leader_transmitter.sv
// SPI leader: serialises one data_length-bit word per start (MSB first, sck idle low), then a commit clock with ss high.
// Define SPI_LEADER_MISO_EN to add the miso input and rx_data output receive path.
module spi_leader_transmitter #(
  parameter int data_length = 8,
  parameter int clk_div     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [data_length-1:0] data_in,
`ifdef SPI_LEADER_MISO_EN
  input  logic                   miso,
  output logic [data_length-1:0] rx_data,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   sck,
  output logic                   ss,
  output logic                   mosi
);

  localparam int DIV_W = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int BIT_W = $clog2(data_length + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clk_div - 1);
  localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(data_length);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DATA_HIGH,
    DATA_LOW,
    COMMIT_LOW,
    COMMIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bits_q, bits_d;
  logic [data_length-1:0] shift_q, shift_d;
  logic                   sck_q, sck_d;
  logic                   ss_q, ss_d;
  logic                   mosi_q, mosi_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    sck_d   = sck_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tick    = (div_q == DIV_LAST);

    // Every state but IDLE lasts exactly one sck half-period.
    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = data_in;
          bits_d  = BITS_ALL;
          ss_d    = 1'b0;
          mosi_d  = data_in[data_length-1];
          busy_d  = 1'b1;
          div_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = DATA_HIGH;
        end
      end
      DATA_HIGH: begin
        if (tick) begin
          sck_d  = 1'b0;
          bits_d = bits_q - BIT_W'(1);
          if (bits_q > BIT_W'(1)) begin
            shift_d = shift_q << 1;
            mosi_d  = shift_q[data_length-2];
            state_d = DATA_LOW;
          end else begin
            // ss rises with the last data fall so the next rise is the commit clock.
            mosi_d  = 1'b0;
            ss_d    = 1'b1;
            state_d = COMMIT_LOW;
          end
        end
      end
      DATA_LOW: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = DATA_HIGH;
        end
      end
      COMMIT_LOW: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = COMMIT_HIGH;
        end
      end
      COMMIT_HIGH: begin
        if (tick) begin
          sck_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SPI_LEADER_MISO_EN
  logic [data_length-1:0] rx_shift_q, rx_shift_d;
  logic [data_length-1:0] rx_data_q, rx_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift_q <= '0;
      rx_data_q  <= '0;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Sample on the edges that raise sck for a data bit; the commit rise is skipped.
  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    if (tick && (state_q == SETUP || state_q == DATA_LOW)) begin
      rx_shift_d = {rx_shift_q[data_length-2:0], miso};
    end
    if (tick && state_q == COMMIT_HIGH) begin
      rx_data_d = rx_shift_q;
    end
  end

  assign rx_data = rx_data_q;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign sck  = sck_q;
  assign ss   = ss_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_leader_transmitter.sv
// Bench for spi_leader_transmitter: follower model plus frame scoreboard on the main instance,
// directed checks on clk_div=1 and data_length=16 instances.
`timescale 1ns/1ps
module tb_spi_leader_transmitter;
  localparam int D = 8;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, done, sck, ss, mosi;

  logic       c1_start = 1'b0;
  logic [7:0] c1_data = 8'h00;
  logic       c1_busy, c1_done, c1_sck, c1_ss, c1_mosi;

  logic        w_start = 1'b0;
  logic [15:0] w_data = 16'h0000;
  logic        w_busy, w_done, w_sck, w_ss, w_mosi;

  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SPI_LEADER_MISO_EN
  logic        miso = 1'b0;
  logic [7:0]  rx_data;
  logic [7:0]  c1_rx;
  logic [15:0] w_rx;
`endif

  spi_leader_transmitter #(.data_length(8), .clk_div(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
`ifdef SPI_LEADER_MISO_EN
    .miso(miso), .rx_data(rx_data),
`endif
    .busy(busy), .done(done), .sck(sck), .ss(ss), .mosi(mosi)
  );

  spi_leader_transmitter #(.data_length(8), .clk_div(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .start(c1_start), .data_in(c1_data),
`ifdef SPI_LEADER_MISO_EN
    .miso(1'b0), .rx_data(c1_rx),
`endif
    .busy(c1_busy), .done(c1_done), .sck(c1_sck), .ss(c1_ss), .mosi(c1_mosi)
  );

  spi_leader_transmitter #(.data_length(16), .clk_div(4)) u_dut_w16 (
    .clk(clk), .rst(rst), .start(w_start), .data_in(w_data),
`ifdef SPI_LEADER_MISO_EN
    .miso(1'b0), .rx_data(w_rx),
`endif
    .busy(w_busy), .done(w_done), .sck(w_sck), .ss(w_ss), .mosi(w_mosi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] rx;
    int         e0;
  } exp_t;
  exp_t sb_q[$];

  logic       prev_sck = 1'b0, prev_ss = 1'b1, prev_mosi = 1'b0;
  int         rises = 0, ss_lo = 0, busy_hi = 0, dones = 0, idle_sck_hi = 0;
  int         last_rise = -100, last_mchg = -100, ss_rise_cyc = -1;
  logic [7:0] fol_sh = 8'h00, fol_data = 8'h00;

  // Follower model and frame scoreboard for the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      rises = 0; ss_lo = 0; busy_hi = 0; fol_sh = 8'h00; ss_rise_cyc = -1;
    end else begin
      if (!ss) ss_lo++;
      if (busy) busy_hi++;
      if (!busy && sck) idle_sck_hi++;
      if (mosi !== prev_mosi && busy) chk("mosi_hold", (cyc - last_rise) >= C, 1);
      if (sck && !prev_sck) begin
        rises++;
        if (!ss) begin
          chk("mosi_setup", (cyc - last_mchg) >= C, 1);
          fol_sh = {fol_sh[6:0], mosi};
        end else begin
          fol_data = fol_sh;
        end
        last_rise = cyc;
      end
      if (ss && !prev_ss) ss_rise_cyc = cyc;
      if (!ss && prev_ss && ss_rise_cyc >= 0) chk("ss_gap", (cyc - ss_rise_cyc) >= C + 1, 1);
      if (done) begin
        dones++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk("follower_data", fol_data, e.data);
          chk("done_latency", cyc - e.e0, (2*D+2)*C);
          chk("sck_rises", rises, D+1);
          chk("ss_low_cycles", ss_lo, 2*D*C);
          chk("busy_cycles", busy_hi, (2*D+2)*C);
`ifdef SPI_LEADER_MISO_EN
          chk("rx_data", rx_data, e.rx);
`endif
        end
        rises = 0; ss_lo = 0; busy_hi = 0;
      end
    end
    if (mosi !== prev_mosi) last_mchg = cyc;
    prev_sck = sck; prev_ss = ss; prev_mosi = mosi;
  end

`ifdef SPI_LEADER_MISO_EN
  logic [7:0] miso_sh = 8'h00;
  logic       m_prev_ss = 1'b1, m_prev_sck = 1'b0;
  // Follower transmit side: reloads at ss fall, shifts on each sck fall.
  always @(negedge clk) begin
    if (!ss && m_prev_ss) miso_sh = 8'h5A;
    else if (!sck && m_prev_sck) miso_sh = miso_sh << 1;
    miso = miso_sh[7];
    m_prev_ss = ss; m_prev_sck = sck;
  end
`endif

  int         c1_rises = 0, c1_done_cyc = -1;
  logic [7:0] c1_word = 8'h00;
  logic [1:0] c1_end = 2'b00;
  logic       c1_prev = 1'b0;
  always @(negedge clk) begin
    if (c1_sck && !c1_prev) begin
      c1_rises++;
      if (!c1_ss) c1_word = {c1_word[6:0], c1_mosi};
    end
    if (c1_done) begin c1_done_cyc = cyc; c1_end = {c1_ss, c1_mosi}; end
    c1_prev = c1_sck;
  end

  int          w_rises = 0, w_done_cyc = -1;
  logic [15:0] w_word = 16'h0000;
  logic        w_prev = 1'b0;
  always @(negedge clk) begin
    if (w_sck && !w_prev) begin
      w_rises++;
      if (!w_ss) w_word = {w_word[14:0], w_mosi};
    end
    if (w_done) w_done_cyc = cyc;
    w_prev = w_sck;
  end

  task automatic wait_dones(input int n, input int budget);
    int t = 0;
    while (dones < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_count", dones, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, t, d0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sck, ss, mosi, busy, done}, 5'b01000);
`ifdef SPI_LEADER_MISO_EN
    chk("reset_rx_data", rx_data, 8'h00);
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame 0xA5, data_in changed right after acceptance.
    data_in = 8'hA5; start = 1'b1; e0 = cyc + 1;
    sb_q.push_back('{data: 8'hA5, rx: 8'h5A, e0: e0});
    @(negedge clk);
    start = 1'b0; data_in = 8'h00;
    wait_dones(1, 200);
    repeat (5) @(negedge clk);

    // Start held high: back-to-back 0x3C then 0xC3, then pulses while busy.
    data_in = 8'h3C; start = 1'b1; e0 = cyc + 1;
    sb_q.push_back('{data: 8'h3C, rx: 8'h5A, e0: e0});
    sb_q.push_back('{data: 8'hC3, rx: 8'h5A, e0: e0 + (2*D+2)*C + 1});
    @(negedge clk);
    data_in = 8'hC3;
    while (cyc < e0 + (2*D+2)*C + 1) @(negedge clk);
    start = 1'b0; data_in = 8'h11;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_dones(3, 300);
    repeat (100) @(negedge clk);
    chk("no_extra_frame", dones, 3);
    chk("idle_after_pulses", busy, 1'b0);

    // Reset in the middle of a frame.
    data_in = 8'h96; start = 1'b1; e0 = cyc + 1;
    sb_q.push_back('{data: 8'h96, rx: 8'h5A, e0: e0});
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {sck, ss, mosi, busy, done}, 5'b01000);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    d0 = dones;
    repeat (100) @(negedge clk);
    chk("no_done_after_abort", dones, d0);
    data_in = 8'h69; start = 1'b1; e0 = cyc + 1;
    sb_q.push_back('{data: 8'h69, rx: 8'h5A, e0: e0});
    @(negedge clk);
    start = 1'b0;
    wait_dones(d0 + 1, 200);

    // clk_div = 1, all ones.
    @(negedge clk);
    c1_data = 8'hFF; c1_start = 1'b1; e0 = cyc + 1;
    c1_rises = 0; c1_done_cyc = -1; c1_word = 8'h00;
    @(negedge clk);
    c1_start = 1'b0;
    t = 0;
    while (c1_done_cyc < 0 && t < 200) begin @(negedge clk); t++; end
    chk("c1_done_latency", c1_done_cyc - e0, 18);
    chk("c1_sck_rises", c1_rises, 9);
    chk("c1_word", c1_word, 8'hFF);
    chk("c1_end_ss_mosi", c1_end, 2'b10);

    // data_length = 16, 0x8001.
    @(negedge clk);
    w_data = 16'h8001; w_start = 1'b1; e0 = cyc + 1;
    w_rises = 0; w_done_cyc = -1; w_word = 16'h0000;
    @(negedge clk);
    w_start = 1'b0;
    t = 0;
    while (w_done_cyc < 0 && t < 400) begin @(negedge clk); t++; end
    chk("w16_done_latency", w_done_cyc - e0, 34*C);
    chk("w16_sck_rises", w_rises, 17);
    chk("w16_word", w_word, 16'h8001);

    repeat (5) @(negedge clk);
    chk("sck_high_while_idle", idle_sck_hi, 0);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
